ritc_multichan_align_buffer: RTL and testbench

Single-clock, multi-channel elastic buffer that lines up NCHAN independently-valid RITC sample streams into one common, word-aligned output stream on the system clock. Each channel writes into its own ring buffer. Reading starts on all channels together once every channel holds at least a programmable fill level. Underflow or overflow on any channel flushes every channel and re-arms the fill. It sits downstream of the per-channel ISERDES/phase-transfer stages and upstream of the trigger/digitiser logic.

---
 rtl/ritc_align_pkg.sv | 24 ++
 rtl/ritc_align_chan.sv | 52 +++++
 rtl/ritc_multichan_align_buffer.sv | 122 ++++++++++++
 tb/tb_ritc_multichan_align_buffer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/ritc_align_pkg.sv
// Shared types and helpers for the multi-channel RITC alignment buffer.
// Holds the FSM state encoding, default sizing and the start-threshold clamp.
package ritc_align_pkg;

  localparam int DEPTH_LOG2_DEF = 2;
  localparam int PTR_W_DEF      = DEPTH_LOG2_DEF + 1;

  typedef enum logic {
    ST_FILL,
    ST_RUN
  } state_t;

  // A threshold of 0 would start reading from empty rings, so it behaves as 1.
  function automatic int unsigned clamp_thresh(input int unsigned thresh,
                                               input int unsigned depth);
    if (thresh == 0)
      return 1;
    else if (thresh > depth)
      return depth;
    else
      return thresh;
  endfunction

endpackage

// File: rtl/ritc_align_chan.sv
// One channel of the alignment buffer: a ring with wrap-bit pointers.
// Reports overflow/underflow combinationally so the top can flush every channel.
module ritc_align_chan
  import ritc_align_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH-1:0]      rd_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  ovf,
  output logic                  unf
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = DEPTH[DEPTH_LOG2:0];

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;

  assign level   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // A full ring may still accept a write when the same edge frees a slot.
  assign ovf = wr_en && !rd_en && (level == FULL);
  assign unf = rd_en && (level == '0);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_en)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush && !rst)
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ritc_multichan_align_buffer.sv
// Lines up NCHAN independently-valid sample streams into one aligned output word.
// Reading starts on all channels together; any channel error flushes them all.
module ritc_multichan_align_buffer
  import ritc_align_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int NCHAN      = 3,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NCHAN*WIDTH-1:0]  DATA_IN,
  input  logic [NCHAN-1:0]        VALID_IN,
  input  logic [DEPTH_LOG2:0]     THRESH,
  input  logic                    CLR_ERR,
  output logic [NCHAN*WIDTH-1:0]  DATA_OUT,
  output logic                    VALID_OUT,
  output logic                    RUNNING,
  output logic [NCHAN-1:0]        ERR_OVF,
  output logic [NCHAN-1:0]        ERR_UNF
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = DEPTH_LOG2 + 1;

  state_t                 state;
  state_t                 state_next;
  logic [PTR_W-1:0]       level [NCHAN];
  logic [NCHAN-1:0]       ovf;
  logic [NCHAN-1:0]       unf;
  logic [NCHAN*WIDTH-1:0] rd_word;
  logic [PTR_W-1:0]       thr_eff;
  logic                   all_ready;
  logic                   rd_en;
  logic                   err;

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    ritc_align_chan #(
      .WIDTH      (WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_chan (
      .clk     (CLK),
      .rst     (RST),
      .flush   (err),
      .wr_en   (VALID_IN[c]),
      .rd_en   (rd_en),
      .wr_data (DATA_IN[c*WIDTH +: WIDTH]),
      .rd_data (rd_word[c*WIDTH +: WIDTH]),
      .level   (level[c]),
      .ovf     (ovf[c]),
      .unf     (unf[c])
    );
  end

  assign err = |{ovf, unf};

  always_comb begin
    thr_eff   = PTR_W'(clamp_thresh(int'(THRESH), DEPTH));
    all_ready = 1'b1;
    for (int c = 0; c < NCHAN; c++) begin
      if (level[c] < thr_eff)
        all_ready = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)
      state <= ST_FILL;
    else
      state <= state_next;
  end

  // The first read happens on the very edge that leaves FILL.
  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    case (state)
      ST_FILL: begin
        if (all_ready) begin
          rd_en      = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        rd_en = 1'b1;
      end
      default: begin
        state_next = ST_FILL;
      end
    endcase
    if (err)
      state_next = ST_FILL;
  end

  assign RUNNING = (state == ST_RUN);

  // DATA_OUT keeps its last word across an error so downstream sees no garbage.
  always_ff @(posedge CLK) begin
    if (RST) begin
      DATA_OUT  <= '0;
      VALID_OUT <= 1'b0;
    end else if (err) begin
      VALID_OUT <= 1'b0;
    end else if (rd_en) begin
      DATA_OUT  <= rd_word;
      VALID_OUT <= 1'b1;
    end else begin
      VALID_OUT <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ERR_OVF <= '0;
      ERR_UNF <= '0;
    end else begin
      ERR_OVF <= (CLR_ERR ? '0 : ERR_OVF) | ovf;
      ERR_UNF <= (CLR_ERR ? '0 : ERR_UNF) | unf;
    end
  end

endmodule

// File: tb/tb_ritc_multichan_align_buffer.sv
// Directed bench for the alignment buffer: a per-cycle vector table for
// alignment, underflow and skew, then hand-written multi-cycle corner sequences.
module tb_ritc_multichan_align_buffer;

  typedef struct {
    logic        rst;
    logic [2:0]  valid;
    logic [11:0] data;
    logic [2:0]  thresh;
    logic        clr;
    logic [11:0] exp_data;
    logic        exp_valid;
    logic        exp_running;
    logic [2:0]  exp_ovf;
    logic [2:0]  exp_unf;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [11:0] data_in;
  logic [2:0]  valid_in;
  logic [2:0]  thresh;
  logic        clr_err;
  logic [11:0] data_out;
  logic        valid_out;
  logic        running;
  logic [2:0]  err_ovf;
  logic [2:0]  err_unf;

  int n_vectors;
  int n_miscompares;

  vec_t vecs [17];

  ritc_multichan_align_buffer #(
    .WIDTH      (4),
    .NCHAN      (3),
    .DEPTH_LOG2 (2)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .DATA_IN   (data_in),
    .VALID_IN  (valid_in),
    .THRESH    (thresh),
    .CLR_ERR   (clr_err),
    .DATA_OUT  (data_out),
    .VALID_OUT (valid_out),
    .RUNNING   (running),
    .ERR_OVF   (err_ovf),
    .ERR_UNF   (err_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [2:0] v, input logic [11:0] d,
                              input logic [2:0] th, input logic c, input logic [11:0] ed,
                              input logic ev, input logic er, input logic [2:0] eo,
                              input logic [2:0] eu);
    vec_t x;
    x.rst = r; x.valid = v; x.data = d; x.thresh = th; x.clr = c;
    x.exp_data = ed; x.exp_valid = ev; x.exp_running = er;
    x.exp_ovf = eo; x.exp_unf = eu;
    return x;
  endfunction

  task automatic check_output(input string name, input vec_t x);
    n_vectors++;
    if (data_out !== x.exp_data) begin
      n_miscompares++;
      $display("[TB] FAIL %s data_out: got %h expected %h", name, data_out, x.exp_data);
    end
    if (valid_out !== x.exp_valid) begin
      n_miscompares++;
      $display("[TB] FAIL %s valid_out: got %b expected %b", name, valid_out, x.exp_valid);
    end
    if (running !== x.exp_running) begin
      n_miscompares++;
      $display("[TB] FAIL %s running: got %b expected %b", name, running, x.exp_running);
    end
    if (err_ovf !== x.exp_ovf) begin
      n_miscompares++;
      $display("[TB] FAIL %s err_ovf: got %b expected %b", name, err_ovf, x.exp_ovf);
    end
    if (err_unf !== x.exp_unf) begin
      n_miscompares++;
      $display("[TB] FAIL %s err_unf: got %b expected %b", name, err_unf, x.exp_unf);
    end
  endtask

  task automatic apply_stimulus(input string name, input vec_t x);
    @(negedge clk);
    rst      = x.rst;
    valid_in = x.valid;
    data_in  = x.data;
    thresh   = x.thresh;
    clr_err  = x.clr;
    @(posedge clk);
    #1;
    check_output(name, x);
  endtask

  initial begin
    n_vectors     = 0;
    n_miscompares = 0;
    rst      = 1'b1;
    valid_in = '0;
    data_in  = '0;
    thresh   = 3'd2;
    clr_err  = 1'b0;

    // lane c carries c*4+k; the data word is {lane2, lane1, lane0}
    vecs[0]  = mk(1, 3'b000, 12'h000, 2, 0, 12'h000, 0, 0, 3'b000, 3'b000);
    vecs[1]  = mk(0, 3'b111, 12'h840, 2, 0, 12'h000, 0, 0, 3'b000, 3'b000);
    vecs[2]  = mk(0, 3'b111, 12'h951, 2, 0, 12'h000, 0, 0, 3'b000, 3'b000);
    vecs[3]  = mk(0, 3'b111, 12'hA62, 2, 0, 12'h840, 1, 1, 3'b000, 3'b000);
    vecs[4]  = mk(0, 3'b111, 12'hB73, 2, 0, 12'h951, 1, 1, 3'b000, 3'b000);
    vecs[5]  = mk(0, 3'b111, 12'hC84, 2, 0, 12'hA62, 1, 1, 3'b000, 3'b000);
    vecs[6]  = mk(0, 3'b011, 12'h095, 2, 0, 12'hB73, 1, 1, 3'b000, 3'b000);
    vecs[7]  = mk(0, 3'b011, 12'h0A6, 2, 0, 12'hC84, 1, 1, 3'b000, 3'b000);
    vecs[8]  = mk(0, 3'b111, 12'hFB7, 2, 0, 12'hC84, 0, 0, 3'b000, 3'b100);
    vecs[9]  = mk(0, 3'b000, 12'h000, 2, 0, 12'hC84, 0, 0, 3'b000, 3'b100);
    // skew: channel 1 leads channel 0 by one cycle, channel 2 lags it by two
    vecs[10] = mk(0, 3'b010, 12'h040, 1, 0, 12'hC84, 0, 0, 3'b000, 3'b100);
    vecs[11] = mk(0, 3'b011, 12'h050, 1, 0, 12'hC84, 0, 0, 3'b000, 3'b100);
    vecs[12] = mk(0, 3'b011, 12'h061, 1, 0, 12'hC84, 0, 0, 3'b000, 3'b100);
    vecs[13] = mk(0, 3'b111, 12'h872, 1, 0, 12'hC84, 0, 0, 3'b000, 3'b100);
    vecs[14] = mk(0, 3'b111, 12'h983, 1, 0, 12'h840, 1, 1, 3'b000, 3'b100);
    vecs[15] = mk(0, 3'b111, 12'hA94, 1, 0, 12'h951, 1, 1, 3'b000, 3'b100);
    vecs[16] = mk(0, 3'b111, 12'hBA5, 1, 1, 12'hA62, 1, 1, 3'b000, 3'b000);

    for (int i = 0; i < 17; i++)
      apply_stimulus($sformatf("table[%0d]", i), vecs[i]);

    // underflow on the same edge as CLR_ERR keeps its flag
    apply_stimulus("unf_setup",   mk(0, 3'b011, 12'h0B6, 1, 0, 12'hB73, 1, 1, 3'b000, 3'b000));
    apply_stimulus("unf_and_clr", mk(0, 3'b111, 12'h000, 1, 1, 12'hB73, 0, 0, 3'b000, 3'b100));
    apply_stimulus("refill",      mk(0, 3'b111, 12'h321, 1, 0, 12'hB73, 0, 0, 3'b000, 3'b100));
    apply_stimulus("rerun",       mk(0, 3'b111, 12'h654, 1, 0, 12'h321, 1, 1, 3'b000, 3'b100));

    // reset mid-RUN with a word still buffered
    apply_stimulus("rst_mid_run", mk(1, 3'b111, 12'h987, 1, 0, 12'h000, 0, 0, 3'b000, 3'b000));
    apply_stimulus("post_rst_0",  mk(0, 3'b000, 12'h000, 1, 0, 12'h000, 0, 0, 3'b000, 3'b000));
    apply_stimulus("post_rst_1",  mk(0, 3'b000, 12'h000, 1, 0, 12'h000, 0, 0, 3'b000, 3'b000));

    // overflow: only channel 2 fills, fifth write overflows
    apply_stimulus("ovf_w1", mk(0, 3'b100, 12'h100, 4, 0, 12'h000, 0, 0, 3'b000, 3'b000));
    apply_stimulus("ovf_w2", mk(0, 3'b100, 12'h200, 4, 0, 12'h000, 0, 0, 3'b000, 3'b000));
    apply_stimulus("ovf_w3", mk(0, 3'b100, 12'h300, 4, 0, 12'h000, 0, 0, 3'b000, 3'b000));
    apply_stimulus("ovf_w4", mk(0, 3'b100, 12'h400, 4, 0, 12'h000, 0, 0, 3'b000, 3'b000));
    apply_stimulus("ovf_w5", mk(0, 3'b100, 12'h500, 4, 0, 12'h000, 0, 0, 3'b100, 3'b000));
    apply_stimulus("ovf_flushed_wr", mk(0, 3'b111, 12'h777, 1, 0, 12'h000, 0, 0, 3'b100, 3'b000));
    apply_stimulus("clr_alone",      mk(0, 3'b000, 12'h000, 1, 1, 12'h777, 1, 1, 3'b000, 3'b000));
    apply_stimulus("unf_all",        mk(0, 3'b000, 12'h000, 1, 0, 12'h777, 0, 0, 3'b000, 3'b111));

    // THRESH above DEPTH behaves as DEPTH
    apply_stimulus("clamp_w1", mk(0, 3'b111, 12'h111, 7, 0, 12'h777, 0, 0, 3'b000, 3'b111));
    apply_stimulus("clamp_w2", mk(0, 3'b111, 12'h222, 7, 0, 12'h777, 0, 0, 3'b000, 3'b111));
    apply_stimulus("clamp_w3", mk(0, 3'b111, 12'h333, 7, 0, 12'h777, 0, 0, 3'b000, 3'b111));
    apply_stimulus("clamp_w4", mk(0, 3'b111, 12'h444, 7, 0, 12'h777, 0, 0, 3'b000, 3'b111));
    apply_stimulus("clamp_start", mk(0, 3'b111, 12'h555, 7, 0, 12'h111, 1, 1, 3'b000, 3'b111));

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
